branch_resolve_unit: RTL and testbench

//  Parametrised successor to Signal_Branch for the multicycle RISC. Resolves conditional

---
 rtl/branch_resolve_unit.sv | 202 ++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit for the multicycle RISC.
// Owns the N,Z,C,V status word and evaluates conditional branches, BAL and jumps.
// A taken transfer raises a redirect to fetch, which is held until fetch accepts it.
// A timed flush of the younger stages follows. A JAL also emits a one-cycle link write.
module branch_resolve_unit #(
    parameter int PC_W      = 16,
    parameter int FLUSH_CYC = 2,
    parameter int BYPASS    = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      ins,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  rs_val,
    input  logic             flag_we,
    input  logic [3:0]       flag_in,
    output logic [3:0]       psw,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [PC_W-1:0]  redir_pc,
    output logic             flush,
    output logic             link_we,
    output logic [PC_W-1:0]  link_data,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt
);

    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDIRECT,
        S_FLUSH
    } state_t;

    state_t state, state_nxt;

    logic [FC_W-1:0] flush_cnt;
    logic            accept;
    logic [3:0]      eval_f;
    logic [4:0]      opcode;
    logic [2:0]      cond;
    logic            cond_true;
    logic            taken_p0;
    logic            is_cond_p0;
    logic            is_link_p0;
    logic [PC_W-1:0] tgt_p0;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [PC_W-1:0] sext8(input logic [7:0] o);
        logic signed [PC_W-1:0] s;
        s = {{(PC_W-8){o[7]}}, o};
        return $unsigned(s);
    endfunction

    function automatic logic [PC_W-1:0] sext11(input logic [10:0] o);
        logic signed [PC_W-1:0] s;
        s = {{(PC_W-11){o[10]}}, o};
        return $unsigned(s);
    endfunction

    assign opcode = ins[15:11];
    assign cond   = ins[10:8];
    assign accept = req_valid & req_ready;
    // With bypass, flags written by the ALU this very cycle decide the branch.
    assign eval_f = ((BYPASS != 0) && flag_we) ? flag_in : psw;

    // Condition-code evaluation against {N,Z,C,V}.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = ~eval_f[2];
            3'b001:  cond_true =  eval_f[2];
            3'b010:  cond_true =  eval_f[1];
            3'b011:  cond_true = ~eval_f[1];
            3'b100:  cond_true =  eval_f[3];
            3'b101:  cond_true = ~eval_f[3];
            3'b110:  cond_true =  eval_f[0];
            default: cond_true = ~eval_f[0];
        endcase
    end

    // Instruction decode: taken decision, target and link request.
    always_comb begin
        taken_p0   = 1'b0;
        is_cond_p0 = 1'b0;
        is_link_p0 = 1'b0;
        tgt_p0     = '0;
        case (opcode)
            5'b11000: begin
                is_cond_p0 = 1'b1;
                taken_p0   = cond_true;
                tgt_p0     = pc + sext8(ins[7:0]);
            end
            5'b11001, 5'b10000: begin
                taken_p0 = 1'b1;
                tgt_p0   = pc + sext11(ins[10:0]);
            end
            5'b10001: begin
                taken_p0   = 1'b1;
                is_link_p0 = 1'b1;
                tgt_p0     = pc + sext11(ins[10:0]);
            end
            5'b10010: begin
                taken_p0   = 1'b1;
                is_link_p0 = 1'b1;
                tgt_p0     = rs_val;
            end
            5'b10011: begin
                taken_p0 = 1'b1;
                tgt_p0   = rs_val;
            end
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state and request handshake.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && taken_p0) state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (redir_ready) state_nxt = (FLUSH_CYC == 0) ? S_IDLE : S_FLUSH;
            end
            S_FLUSH: begin
                if (flush_cnt == '0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status word: the ALU may write it in any state.
    always_ff @(posedge clk) begin
        if (rst)          psw <= 4'b0000;
        else if (flag_we) psw <= flag_in;
    end

    // Redirect, link, flush timing and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            flush       <= 1'b0;
            flush_cnt   <= '0;
            link_we     <= 1'b0;
            link_data   <= '0;
            taken_cnt   <= '0;
            ntaken_cnt  <= '0;
        end else begin
            link_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (taken_p0) begin
                            redir_valid <= 1'b1;
                            redir_pc    <= tgt_p0;
                            taken_cnt   <= sat_inc(taken_cnt);
                            if (is_link_p0) begin
                                link_we   <= 1'b1;
                                link_data <= pc + {{(PC_W-1){1'b0}}, 1'b1};
                            end
                        end else if (is_cond_p0) begin
                            ntaken_cnt <= sat_inc(ntaken_cnt);
                        end
                    end
                end
                S_REDIRECT: begin
                    if (redir_ready) begin
                        redir_valid <= 1'b0;
                        if (FLUSH_CYC > 0) begin
                            flush     <= 1'b1;
                            flush_cnt <= FC_W'(FLUSH_CYC - 1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == '0) flush <= 1'b0;
                    else                 flush_cnt <= flush_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized
// transactions against a behavioural model. A second instance covers bypass,
// zero-length flush and counter saturation.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [15:0] ins, pc, rs_val;
    logic        flag_we;
    logic [3:0]  flag_in, psw;
    logic        redir_valid, redir_ready;
    logic [15:0] redir_pc;
    logic        flush, link_we;
    logic [15:0] link_data, taken_cnt, ntaken_cnt;

    logic        req_valid1, req_ready1, flag_we1;
    logic [3:0]  flag_in1, psw1;
    logic        redir_valid1, redir_ready1;
    logic [15:0] redir_pc1, link_data1;
    logic        flush1, link_we1;
    logic [2:0]  taken_cnt1, ntaken_cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] psw_m, psw1_m;
    int tk_m, nt_m, tk1_m, nt1_m;

    branch_resolve_unit #(.PC_W(16), .FLUSH_CYC(2), .BYPASS(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .ins(ins), .pc(pc), .rs_val(rs_val), .flag_we(flag_we), .flag_in(flag_in),
        .psw(psw), .redir_valid(redir_valid), .redir_ready(redir_ready),
        .redir_pc(redir_pc), .flush(flush), .link_we(link_we), .link_data(link_data),
        .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
    );

    branch_resolve_unit #(.PC_W(16), .FLUSH_CYC(0), .BYPASS(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .ins(ins), .pc(pc), .rs_val(rs_val), .flag_we(flag_we1), .flag_in(flag_in1),
        .psw(psw1), .redir_valid(redir_valid1), .redir_ready(redir_ready1),
        .redir_pc(redir_pc1), .flush(flush1), .link_we(link_we1), .link_data(link_data1),
        .taken_cnt(taken_cnt1), .ntaken_cnt(ntaken_cnt1)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // Architectural meaning of an instruction given flags {N,Z,C,V}.
    task automatic model(input logic [15:0] i, input logic [15:0] p, input logic [15:0] r,
                         input logic [3:0] f, output bit tk, output bit cnd,
                         output bit lnk, output logic [15:0] tg);
        int op, o8, o11;
        logic [7:0] tbl;
        op  = int'(i[15:11]);
        o8  = int'(i[7:0]);  if (o8 > 127)   o8  -= 256;
        o11 = int'(i[10:0]); if (o11 > 1023) o11 -= 2048;
        // index = cond: NE EQ CS CC MI PL VS VC
        tbl = {~f[0], f[0], ~f[3], f[3], ~f[1], f[1], f[2], ~f[2]};
        tk = 0; cnd = 0; lnk = 0; tg = 16'h0000;
        if (op == 24) begin
            cnd = 1; tk = tbl[i[10:8]]; tg = 16'((int'(p) + o8) & 16'hFFFF);
        end else if (op == 25 || op == 16 || op == 17) begin
            tk = 1; lnk = (op == 17); tg = 16'((int'(p) + o11) & 16'hFFFF);
        end else if (op == 18 || op == 19) begin
            tk = 1; lnk = (op == 18); tg = r;
        end
    endtask

    task automatic reset_models();
        psw_m = 4'h0; psw1_m = 4'h0;
        tk_m = 0; nt_m = 0; tk1_m = 0; nt1_m = 0;
    endtask

    // One transaction on the main instance; rdly = cycles fetch stalls the redirect.
    task automatic run0(input logic [15:0] i, input logic [15:0] p, input logic [15:0] r,
                        input logic fwe, input logic [3:0] fin, input int rdly,
                        input bit rst_fl);
        bit tk, cnd, lnk;
        logic [15:0] tg;
        logic fw;
        logic [3:0] fi;
        int n;
        @(negedge clk);
        check_val("idle_ready", req_ready, 1);
        model(i, p, r, psw_m, tk, cnd, lnk, tg);
        req_valid = 1; ins = i; pc = p; rs_val = r; flag_we = fwe; flag_in = fin;
        redir_ready = 0;
        if (fwe) psw_m = fin;
        if (tk) tk_m = sat(tk_m, 65535);
        else if (cnd) nt_m = sat(nt_m, 65535);
        @(negedge clk);
        req_valid = 0; flag_we = 0;
        check_val("psw", psw, psw_m);
        check_val("taken_cnt", taken_cnt, tk_m);
        check_val("ntaken_cnt", ntaken_cnt, nt_m);
        check_val("redir_valid", redir_valid, tk);
        check_val("link_we", link_we, lnk);
        if (!tk) begin
            check_val("ready_after_nt", req_ready, 1);
            return;
        end
        check_val("redir_pc", redir_pc, tg);
        if (lnk) check_val("link_data", link_data, 16'(p + 16'd1));
        check_val("busy_ready", req_ready, 0);
        for (int k = 0; k < rdly; k++) begin
            fw = 1'($urandom_range(0, 1)); fi = 4'($urandom);
            req_valid = 1; ins = 16'hC800; flag_we = fw; flag_in = fi;
            @(negedge clk);
            if (fw) psw_m = fi;
            check_val("hold_valid", redir_valid, 1);
            check_val("hold_pc", redir_pc, tg);
            check_val("hold_link_we", link_we, 0);
            check_val("hold_taken_cnt", taken_cnt, tk_m);
            check_val("hold_psw", psw, psw_m);
        end
        req_valid = 0; flag_we = 0; redir_ready = 1;
        @(negedge clk);
        redir_ready = 0;
        check_val("redir_drop", redir_valid, 0);
        check_val("flush_start", flush, 1);
        if (rst_fl) begin
            rst = 1;
            @(negedge clk);
            rst = 0;
            reset_models();
            check_val("rst_flush", flush, 0);
            check_val("rst_psw", psw, 0);
            check_val("rst_tk", taken_cnt, 0);
            check_val("rst_nt", ntaken_cnt, 0);
            check_val("rst_ready", req_ready, 1);
            check_val("rst_rv", redir_valid, 0);
            return;
        end
        n = 0;
        while (flush && n < 20) begin
            check_val("flush_ready", req_ready, 0);
            n++;
            @(negedge clk);
        end
        check_val("flush_len", n, 2);
        check_val("post_flush_ready", req_ready, 1);
    endtask

    // One transaction on the bypass / no-flush / 3-bit-counter instance.
    task automatic run1(input logic [15:0] i, input logic [15:0] p,
                        input logic fwe, input logic [3:0] fin);
        bit tk, cnd, lnk;
        logic [15:0] tg;
        @(negedge clk);
        check_val("b_idle_ready", req_ready1, 1);
        model(i, p, 16'h0000, fwe ? fin : psw1_m, tk, cnd, lnk, tg);
        req_valid1 = 1; ins = i; pc = p; rs_val = 16'h0000; flag_we1 = fwe; flag_in1 = fin;
        if (fwe) psw1_m = fin;
        if (tk) tk1_m = sat(tk1_m, 7);
        else if (cnd) nt1_m = sat(nt1_m, 7);
        @(negedge clk);
        req_valid1 = 0; flag_we1 = 0;
        check_val("b_redir_valid", redir_valid1, tk);
        check_val("b_taken_cnt", taken_cnt1, tk1_m);
        check_val("b_ntaken_cnt", ntaken_cnt1, nt1_m);
        check_val("b_psw", psw1, psw1_m);
        if (tk) begin
            check_val("b_redir_pc", redir_pc1, tg);
            @(negedge clk);
            check_val("b_redir_drop", redir_valid1, 0);
            check_val("b_no_flush", flush1, 0);
            check_val("b_ready", req_ready1, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ops [7];
        logic [15:0] ri;
        ops = '{5'b11000, 5'b11000, 5'b11001, 5'b10000, 5'b10001, 5'b10010, 5'b10011};
        rst = 1; req_valid = 0; req_valid1 = 0; ins = 0; pc = 0; rs_val = 0;
        flag_we = 0; flag_in = 0; flag_we1 = 0; flag_in1 = 0;
        redir_ready = 0; redir_ready1 = 1;
        reset_models();
        repeat (3) @(negedge clk);
        check_val("reset_psw", psw, 0);
        check_val("reset_rv", redir_valid, 0);
        check_val("reset_flush", flush, 0);
        check_val("reset_lwe", link_we, 0);
        check_val("reset_rpc", redir_pc, 0);
        check_val("reset_ld", link_data, 0);
        check_val("reset_tk", taken_cnt, 0);
        check_val("reset_nt", ntaken_cnt, 0);
        rst = 0;

        // Z set, BEQ taken, BNE not taken.
        run0(16'h0000, 16'h0000, 16'h0000, 1, 4'b0100, 0, 0);
        run0(16'hC105, 16'h0010, 16'h0000, 0, 4'b0000, 0, 0);
        run0(16'hC0FE, 16'h0010, 16'h0000, 0, 4'b0000, 0, 0);
        // JALrr with a stalled fetch.
        run0(16'h9000, 16'h0100, 16'h2000, 0, 4'b0000, 5, 0);
        // Registered flags: same-cycle flag write does not affect BCS.
        run0(16'h0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 0);
        run0(16'hC203, 16'h0040, 16'h0000, 1, 4'b0010, 0, 0);
        // N and V set, PC at top of range, targets wrap.
        run0(16'h0000, 16'h0000, 16'h0000, 1, 4'b1001, 0, 0);
        run0(16'hC402, 16'hFFFF, 16'h0000, 0, 4'b0000, 1, 0);
        run0(16'hC602, 16'hFFFF, 16'h0000, 0, 4'b0000, 0, 0);
        run0(16'hC702, 16'hFFFF, 16'h0000, 0, 4'b0000, 0, 0);
        run0(16'h8FFE, 16'h0001, 16'h0000, 0, 4'b0000, 2, 0);

        // Bypass instance: same-cycle C makes BCS taken; counters saturate at 7.
        run1(16'hC203, 16'h0040, 1, 4'b0010);
        for (int k = 0; k < 9; k++) run1(16'hC810, 16'(k * 16), 0, 4'b0000);
        for (int k = 0; k < 9; k++) run1(16'hC101, 16'h0020, 0, 4'b0000);

        // Randomized transactions on the main instance.
        for (int k = 0; k < 60; k++) begin
            ri = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ri[15:11] = 5'($urandom);
            else ri[15:11] = ops[$urandom_range(0, 6)];
            run0(ri, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 4'($urandom), int'($urandom_range(0, 3)), 0);
        end

        // Reset while flushing aborts everything.
        run0(16'hC805, 16'h0300, 16'h0000, 1, 4'b1111, 1, 1);
        run0(16'hC105, 16'h0010, 16'h0000, 0, 4'b0000, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
